umtrx_tx_dac_bridge: RTL

Parametrised multi-channel bridge between the TX VITA deframers and the DAC output registers, all on the DSP clock domain. Each channel buffers I/Q samples in a small FIFO, primes before starting, pops one sample per DAC strobe while running, and converts 16-bit I/Q to DAC width. Underruns are detected and counted per channel. Generalises the fixed two-channel, 12-bit strobe-and-hold path to NCH channels with buffering and underrun recovery.

---
 rtl/umtrx_tx_dac_bridge_if.sv | 28 ++
 rtl/umtrx_tx_dac_bridge.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/umtrx_tx_dac_bridge_if.sv
// Sample/strobe/status bundle between the TX deframers and the DAC bridge.
// master = deframer/DAC side, slave = the bridge itself.
interface umtrx_tx_dac_bridge_if #(
  parameter int NCH       = 2,
  parameter int DAC_WIDTH = 12
);
  logic [NCH*32-1:0]        in_tdata;
  logic [NCH-1:0]           in_tvalid;
  logic [NCH-1:0]           in_tready;
  logic [NCH-1:0]           run_i;
  logic [NCH-1:0]           clear;
  logic                     dac_stb;
  logic [NCH*DAC_WIDTH-1:0] dac_i;
  logic [NCH*DAC_WIDTH-1:0] dac_q;
  logic [NCH-1:0]           active;
  logic [NCH-1:0]           underrun;
  logic [NCH*16-1:0]        underrun_count;

  modport master (
    output in_tdata, in_tvalid, run_i, clear, dac_stb,
    input  in_tready, dac_i, dac_q, active, underrun, underrun_count
  );

  modport slave (
    input  in_tdata, in_tvalid, run_i, clear, dac_stb,
    output in_tready, dac_i, dac_q, active, underrun, underrun_count
  );
endinterface

// File: rtl/umtrx_tx_dac_bridge.sv
// NCH-channel TX sample buffer and DAC output stage with prime/stall underrun recovery.
// Optional UMTRX_TX_DAC_ROUND_EN: saturating round-half-up plus one extra output register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | channel off, outputs zero, FIFO still accepts samples
// ST_PRIME | run requested, waiting for PRIME_LEVEL samples buffered
// ST_RUN   | one FIFO pop per dac_stb into the output register
// ST_STALL | recovering from an underrun, re-priming before RUN
module umtrx_tx_dac_bridge #(
  parameter int NCH         = 2,
  parameter int DAC_WIDTH   = 12,
  parameter int FIFO_LOG2   = 3,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  umtrx_tx_dac_bridge_if.slave    bus
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] PRIME_C = PRIME_LEVEL[FIFO_LOG2:0];

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN, ST_STALL} state_t;

`ifdef UMTRX_TX_DAC_ROUND_EN
  // Argument is the kept bits plus the first dropped bit; adding that bit
  // equals adding 2^(15-DAC_WIDTH) before truncation.
  function automatic logic [DAC_WIDTH-1:0] round_s(input logic [DAC_WIDTH:0] s);
    logic [DAC_WIDTH-1:0] t;
    t = s[DAC_WIDTH:1];
    if (s[0] && (t != {1'b0, {(DAC_WIDTH-1){1'b1}}})) t = t + DAC_WIDTH'(1);
    return t;
  endfunction
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [31:0]          mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   cnt_q, cnt_d;
    state_t               state_q, state_d;
    logic [15:0]          smp_i_q, smp_i_d;
    logic [15:0]          smp_q_q, smp_q_d;
    logic                 active_q, active_d;
    logic                 underrun_q, underrun_d;
    logic [15:0]          ucnt_q, ucnt_d;
    logic                 push, pop, full, empty, prime_ok;
    logic [31:0]          rd_word;
    logic                 unused_smp;

    // Count tops out at exactly DEPTH, so its MSB alone means full.
    assign full     = cnt_q[FIFO_LOG2];
    assign empty    = (cnt_q == '0);
    assign prime_ok = (cnt_q >= PRIME_C);
    assign rd_word  = mem_q[rd_ptr_q];
    assign push     = bus.in_tvalid[k] & ~full & ~bus.clear[k];

    always_comb begin
      state_d    = state_q;
      smp_i_d    = smp_i_q;
      smp_q_d    = smp_q_q;
      underrun_d = 1'b0;
      ucnt_d     = ucnt_q;
      pop        = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (bus.run_i[k]) state_d = ST_PRIME;
        end
        ST_PRIME, ST_STALL: begin
          if (!bus.run_i[k])  state_d = ST_IDLE;
          else if (prime_ok)  state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!bus.run_i[k]) begin
            state_d = ST_IDLE;
          end else if (bus.dac_stb) begin
            if (!empty) begin
              pop     = 1'b1;
              smp_i_d = rd_word[31:16];
              smp_q_d = rd_word[15:0];
            end else begin
              underrun_d = 1'b1;
              state_d    = ST_STALL;
              if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (bus.clear[k]) begin
        state_d    = ST_IDLE;
        pop        = 1'b0;
        underrun_d = 1'b0;
      end

      // Anything not sitting in RUN drives zero to the DAC.
      if (state_d != ST_RUN) begin
        smp_i_d = '0;
        smp_q_d = '0;
      end
      active_d = (state_d == ST_RUN);

      wr_ptr_d = push ? wr_ptr_q + FIFO_LOG2'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + FIFO_LOG2'(1) : rd_ptr_q;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + (FIFO_LOG2+1)'(1);
        2'b01:   cnt_d = cnt_q - (FIFO_LOG2+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      if (bus.clear[k]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= ST_IDLE;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        smp_i_q    <= '0;
        smp_q_q    <= '0;
        active_q   <= 1'b0;
        underrun_q <= 1'b0;
        ucnt_q     <= '0;
      end else begin
        state_q    <= state_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        cnt_q      <= cnt_d;
        smp_i_q    <= smp_i_d;
        smp_q_q    <= smp_q_d;
        active_q   <= active_d;
        underrun_q <= underrun_d;
        ucnt_q     <= ucnt_d;
      end
    end

    // Storage carries no reset; occupancy is owned by the pointers and count.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_tdata[32*k +: 32];
    end

    assign unused_smp = ^{smp_i_q, smp_q_q};

`ifdef UMTRX_TX_DAC_ROUND_EN
    logic [DAC_WIDTH-1:0] out_i_q, out_i_d;
    logic [DAC_WIDTH-1:0] out_q_q, out_q_d;

    always_comb begin
      out_i_d = round_s(smp_i_q[15 -: DAC_WIDTH+1]);
      out_q_d = round_s(smp_q_q[15 -: DAC_WIDTH+1]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_i_q <= '0;
        out_q_q <= '0;
      end else begin
        out_i_q <= out_i_d;
        out_q_q <= out_q_d;
      end
    end

    assign bus.dac_i[DAC_WIDTH*k +: DAC_WIDTH] = out_i_q;
    assign bus.dac_q[DAC_WIDTH*k +: DAC_WIDTH] = out_q_q;
`else
    assign bus.dac_i[DAC_WIDTH*k +: DAC_WIDTH] = smp_i_q[15 -: DAC_WIDTH];
    assign bus.dac_q[DAC_WIDTH*k +: DAC_WIDTH] = smp_q_q[15 -: DAC_WIDTH];
`endif

    assign bus.in_tready[k]             = ~full;
    assign bus.active[k]                = active_q;
    assign bus.underrun[k]              = underrun_q;
    assign bus.underrun_count[16*k +: 16] = ucnt_q;
  end

endmodule
